// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue.
//   u64             : 64-bit address/data word
//   branch_entry_t  : one predicted branch as pushed by fetch
//   brq_state_t     : top-level control state (NORMAL / REDIRECT)
//   branch_mispredicts(): prediction vs. outcome compare
package branch_resolve_queue_pkg;

  typedef logic [63:0] u64;

  typedef struct packed {
    u64   pc;
    logic pred_taken;
    u64   pred_target;
  } branch_entry_t;

  typedef enum logic {
    NORMAL   = 1'b0,
    REDIRECT = 1'b1
  } brq_state_t;

  // Fall-through distance for a not-taken branch.
  localparam u64 INSTR_BYTES = 64'd4;

  // A prediction is wrong if the direction differs, or if both say taken
  // but the targets differ. A not-taken prediction's target is irrelevant.
  function automatic logic branch_mispredicts(branch_entry_t entry,
                                              logic          taken,
                                              u64            target);
    return (entry.pred_taken != taken) ||
           (taken && (entry.pred_target != target));
  endfunction

endpackage

// File: rtl/branch_entry_fifo.sv
// In-order circular buffer of predicted branches.
//   clk, rst    : clock, asynchronous active-low reset
//   push        : write push_data at the tail (caller guarantees !full)
//   push_data   : entry to store
//   pop         : drop the head entry (caller guarantees !empty)
//   flush       : discard every entry; wins over push and pop
//   head        : oldest entry (valid when !empty)
//   full, empty : occupancy flags
//   count       : current occupancy, 0..DEPTH
module branch_entry_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  branch_entry_t            push_data,
  input  logic                     pop,
  input  logic                     flush,
  output branch_entry_t            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  branch_entry_t   mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  // NOTE: the entry array has no reset; pointers and count alone define
  // which slots are live, so resetting the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker of predicted branches between fetch and execute.
//   clk, rst                 : clock, asynchronous active-low reset
//   push_*                   : fetch pushes {pc, pred_taken, pred_target}
//   resolve_*                : execute resolves the oldest branch
//   instrAddr_to_feedback,
//   feedback_valid,
//   feedback_branch_taken    : one registered predictor-update beat per resolve
//   redirect_valid,
//   redirect_pc              : one-cycle mispredict redirect to fetch
//   count                    : queue occupancy
//   mispredict_count         : running total of mispredicts (wraps)
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  u64                     push_pc,
  input  logic                   push_pred_taken,
  input  u64                     push_pred_target,
  input  logic                   resolve_valid,
  output logic                   resolve_ready,
  input  logic                   resolve_taken,
  input  u64                     resolve_target,
  output u64                     instrAddr_to_feedback,
  output logic                   feedback_valid,
  output logic                   feedback_branch_taken,
  output logic                   redirect_valid,
  output u64                     redirect_pc,
  output logic [$clog2(DEPTH):0] count,
  output u64                     mispredict_count
);

  brq_state_t    state;
  branch_entry_t head;
  branch_entry_t push_entry;
  logic          full;
  logic          empty;
  logic          push_fire;
  logic          resolve_fire;
  logic          mispredict;
  u64            correct_pc;

  // Handshakes depend only on registered state, never on the valids.
  assign push_ready    = !full  && (state == NORMAL);
  assign resolve_ready = !empty && (state == NORMAL);
  assign push_fire     = push_valid    && push_ready;
  assign resolve_fire  = resolve_valid && resolve_ready;

  assign mispredict = resolve_fire &&
                      branch_mispredicts(head, resolve_taken, resolve_target);
  assign correct_pc = resolve_taken ? resolve_target : head.pc + INSTR_BYTES;

  assign push_entry = '{pc: push_pc, pred_taken: push_pred_taken,
                        pred_target: push_pred_target};

  // A same-cycle push is wrong-path when the resolve mispredicts.
  branch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_fire && !mispredict),
    .push_data (push_entry),
    .pop       (resolve_fire && !mispredict),
    .flush     (mispredict),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // NOTE: state and every registered output use non-blocking assignment so
  // all of them sample the same pre-edge values of head and the inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= NORMAL;
      feedback_valid        <= 1'b0;
      feedback_branch_taken <= 1'b0;
      instrAddr_to_feedback <= '0;
      redirect_valid        <= 1'b0;
      redirect_pc           <= '0;
      mispredict_count      <= '0;
    end else begin
      unique case (state)
        NORMAL:   if (mispredict) state <= REDIRECT;
        REDIRECT: state <= NORMAL;
        default:  state <= NORMAL;
      endcase

      feedback_valid <= resolve_fire;
      if (resolve_fire) begin
        instrAddr_to_feedback <= head.pc;
        feedback_branch_taken <= resolve_taken;
      end

      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc      <= correct_pc;
        mispredict_count <= mispredict_count + 64'd1;
      end
    end
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracker of predicted branches between fetch and execute. It produces the update stream for the 2-bit-counter branch predictor and the mispredict redirect. Fetch pushes each predicted branch. Execute resolves the oldest one. The block compares prediction against outcome, emits one registered feedback beat per resolution, and on a mispredict issues a one-cycle redirect and flushes all younger entries.

## Interface
- DEPTH, 8, queue entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- push_valid  in  1  fetch offers a predicted branch
- push_ready  out  1  push accepted this cycle when high
- push_pc  in  64  branch instruction address
- push_pred_taken  in  1  predicted direction
- push_pred_target  in  64  predicted target (ignored if not taken)
- resolve_valid  in  1  execute resolves oldest branch
- resolve_ready  out  1  queue non-empty
- resolve_taken  in  1  actual direction
- resolve_target  in  64  actual taken target
- instrAddr_to_feedback  out  64  PC of the resolved branch
- feedback_valid  out  1  one-cycle update strobe to predictor
- feedback_branch_taken  out  1  actual direction
- redirect_valid  out  1  one-cycle mispredict redirect
- redirect_pc  out  64  correct next fetch PC
- count  out  $clog2(DEPTH)+1  current occupancy
- mispredict_count  out  64  total mispredicts, wraps

## Operation
- Storage: circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping at DEPTH, plus a count register.
- Push fires on push_valid && push_ready, writing {pc, pred_taken, pred_target} at wr_ptr.
- push_ready = (count != DEPTH) && state == NORMAL.
- Resolve fires on resolve_valid && resolve_ready; resolve_ready = (count != 0) && state == NORMAL.
- Resolve with count == 0: ignored, no feedback.
- Mispredict = (head.pred_taken != resolve_taken) || (resolve_taken && head.pred_target != resolve_target).
- Correct PC = resolve_taken ? resolve_target : head.pc + 64'd4 (mod 2^64).
- FSM has two states, NORMAL and REDIRECT.
  - NORMAL → REDIRECT on a resolve that mispredicts.
  - REDIRECT → NORMAL unconditionally after one cycle.
- Resolve without mispredict: pop the head (rd_ptr+1).
- Resolve with mispredict: discard all entries. Set rd_ptr = wr_ptr and count = 0, and drop any same-cycle push (it is wrong-path).
- Mispredict also increments mispredict_count.
- Simultaneous push and correct resolve: both happen, count unchanged.
- Push while full: not accepted, even if a resolve fires the same cycle, because push_ready does not depend on resolve inputs.
- In REDIRECT, no push and no resolve is accepted.

## Timing
- Registered outputs, asserted the cycle after a resolve fires:
  - feedback_valid = 1 for exactly one cycle, carrying instrAddr_to_feedback = head.pc and feedback_branch_taken = resolve_taken.
  - redirect_valid = 1 with redirect_pc, for that one cycle, only on mispredict; it coincides with feedback_valid.
- Back-to-back resolves give back-to-back feedback beats.
- count and mispredict_count update on the clock edge of the firing cycle.
- push_ready and resolve_ready are combinational from state registers only, with no input-to-output paths.
- Reset values (while rst = 0, asynchronous):
  - feedback_valid, redirect_valid, feedback_branch_taken = 0.
  - instrAddr_to_feedback, redirect_pc, mispredict_count, count, pointers = 0.
  - state = NORMAL, so push_ready = 1 and resolve_ready = 0.
  - Entry storage is not reset.
- Reset mid-operation drops all entries; no feedback or redirect strobe is emitted afterwards.

## Structure
- The common package gains:
  - a branch_entry_t packed struct {u64 pc; logic pred_taken; u64 pred_target};
  - a brq_state_t enum {NORMAL, REDIRECT}.
- Reuse u64 from common.
- One sub-module, branch_entry_fifo: storage, pointers and count.
  - Inputs: push, pop and flush.
  - Outputs: head, full and empty.
- The top handles compare, FSM, output registers and the statistics counter.

## Test plan
- Push 3 branches (pc 0x100/0x200/0x300, predicted not-taken), resolve all not-taken:
  - feedback beats on 3 consecutive cycles with addresses 0x100, 0x200, 0x300 and taken = 0;
  - no redirect; count ends at 0.
- Push pc 0x100 predicted taken to 0x180, resolve taken to 0x1C0:
  - next cycle feedback_valid = 1, taken = 1, redirect_valid = 1, redirect_pc = 0x1C0;
  - mispredict_count = 1.
- Queue holds 4 entries; resolve the head as a direction mispredict (pred taken, actual not-taken, pc 0x400) with a concurrent push:
  - redirect_pc = 0x404, count = 0;
  - push_ready = 0 during REDIRECT, and 1 the following cycle.
- Fill to DEPTH = 8:
  - push_ready = 0; a further push is dropped even with a concurrent correct resolve;
  - count goes 8 → 7.
- Resolve with count = 0, then pc = 0xFFFF_FFFF_FFFF_FFFC mispredicted not-taken:
  - the empty resolve gives no feedback;
  - the second gives redirect_pc = 0.
- Drive rst low with 5 entries queued and a resolve in flight:
  - all outputs go to their reset values immediately;
  - after release, count = 0, resolve_ready = 0, and no stray feedback beat.
